mul_cfg_sequencer: RTL and testbench
====================================

# mul_cfg_sequencer

Per-tile precision/approximation scheduler for the signed Baugh-Wooley/Dadda multipliers in the systolic array. Holds a small table of configurations and converts each entry into the `res_mask`/`appr_mask` vectors the multipliers consume. Steps through the table one tile at a time. Between tiles it drains in-flight products before switching masks, so no product is ever computed with a mix of two configurations.

## Interface
- `N_BIT_RES`, 12: width of `o_res_mask`. It gates result bits 4..15.
- `N_BIT_APPR`, 8: width of `o_appr_mask`. It gates partial-product columns 0..7.
- `N_CFG`, 4: number of configuration table entries. Must be a power of 2.
- `DRAIN_CYCLES`, 3: pipeline depth to flush before a mask change. Range 1..15.
- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_cfg_we`, input, 1: table write strobe.
- `i_cfg_addr`, input, $clog2(N_CFG): table write address.
- `i_cfg_res_bits`, input, 5: number of kept result bits, 4..16.
- `i_cfg_appr_bits`, input, 4: number of approximated LSB columns, 0..8.
- `i_n_cfg`, input, $clog2(N_CFG)+1: number of table entries used, 1..N_CFG. It is sampled on start.
- `i_n_tiles`, input, 16: number of tiles in the job. It is sampled on start.
- `i_start`, input, 1: job start pulse.
- `i_tile_done`, input, 1: pulse from the array at the end of each tile.
- `o_res_mask`, output, N_BIT_RES: precision mask, registered.
- `o_appr_mask`, output, N_BIT_APPR: approximation mask, registered.
- `o_en_ff`, output, 1: enable for the multiplier/array pipeline registers.
- `o_feed_ok`, output, 1: operand feeders may inject new data.
- `o_cfg_idx`, output, $clog2(N_CFG): table index currently applied.
- `o_busy`, output, 1: high in any state other than IDLE.
- `o_done`, output, 1: one-cycle pulse at job end.

## Operation
- Mask encoding, computed from the table entry on load:
  - r = clamp(res_bits, 4, 16); `o_res_mask` = (1<<(r-4))-1. Bit k=1 keeps result bit k+4. Bits set to 0 are replaced by the sign in the multiplier.
  - a = min(appr_bits, 8); `o_appr_mask` = ~((1<<a)-1). Low a columns are zeroed.
  - Example: res_bits=8, appr_bits=2 gives res_mask=12'h00F and appr_mask=8'hFC.
- Table: N_CFG entries of {res_bits, appr_bits}. Reset value of every entry is {16,0}, i.e. exact, full precision. Writes are accepted in any state. A write to the entry being loaded in the same APPLY cycle is not seen; the old value is loaded.
- State machine:
  - IDLE: o_en_ff=0, o_feed_ok=0. `i_start` with `i_n_tiles`≠0 latches the tile count and n_cfg (clamped to 1..N_CFG), sets tile=0 and idx=0, then goes to APPLY. `i_start` with `i_n_tiles`=0 goes to DONE directly and leaves the masks unchanged.
  - APPLY, 1 cycle: o_en_ff=0, o_feed_ok=0. Masks and `o_cfg_idx` are registered from entry idx. Next state is RUN.
  - RUN: o_en_ff=1, o_feed_ok=1.
    - `i_tile_done` on the last tile (tile==n_tiles-1) goes to DRAIN with a final flag set.
    - Otherwise it increments tile, sets idx=(idx+1==n_cfg)?0:idx+1, and goes to DRAIN.
  - DRAIN: o_en_ff=1, o_feed_ok=0. A counter loads DRAIN_CYCLES-1 on entry and decrements each cycle. At 0 the next state is DONE if final, else APPLY.
  - DONE, 1 cycle: o_done=1, o_en_ff=0. Next state is IDLE. Masks keep the last applied value.
- `i_tile_done` outside RUN is ignored. `i_start` while busy is ignored.
- Reset (synchronous, any state):
  - state becomes IDLE; all table entries, tile count, idx and drain counter are cleared to their reset values.
  - Output reset values: o_res_mask all-ones, o_appr_mask all-ones, o_en_ff=0, o_feed_ok=0, o_cfg_idx=0, o_busy=0, o_done=0.
  - Reset mid-job aborts the job with no o_done pulse.

## Timing
- All outputs are registered and derived from the current state and registers. There is no combinational path from inputs to outputs.
- `i_start` sampled at cycle 0 gives APPLY at cycle 1. New masks are visible and RUN begins (o_en_ff=1) at cycle 2.
- `i_tile_done` sampled at cycle t gives DRAIN at t+1..t+DRAIN_CYCLES, APPLY at t+DRAIN_CYCLES+1, and new masks plus RUN at t+DRAIN_CYCLES+2.
- Between tiles, o_feed_ok is low for DRAIN_CYCLES+1 cycles.
- Masks never change while o_en_ff=1.
- o_done is asserted DRAIN_CYCLES+1 cycles after the final `i_tile_done`.

## Test plan
- Reset: hold i_rst 2 cycles -> masks 12'hFFF/8'hFF, en_ff=0, busy=0; after start with no writes, masks remain 12'hFFF/8'hFF (entry default {16,0}).
- Single tile: write entry0={8,2}, start n_tiles=1 n_cfg=1 -> masks 12'h00F/8'hFC at cycle 2, tile_done at cycle 10 -> o_done at cycle 10+DRAIN_CYCLES+1, busy low next cycle.
- Rotation: entries {16,0},{12,4},{4,8}; n_cfg=3, n_tiles=5 -> per-tile o_cfg_idx 0,1,2,0,1; masks match the encoding; feed_ok low exactly DRAIN_CYCLES+1 cycles at each boundary; en_ff high during DRAIN, low during APPLY.
- Clamping/edges: res_bits=2 -> res_mask 12'h000; appr_bits=15 -> appr_mask 8'h00; n_tiles=0 -> o_done pulse at cycle 1, masks unchanged; n_cfg=0 -> treated as 1.
- Ignored events: start during RUN, and tile_done during DRAIN/APPLY/IDLE -> no state, tile count, or index change.
- Reset mid-DRAIN: assert i_rst -> IDLE next cycle, no o_done, table back to {16,0}; a fresh start runs normally.

Source files
------------

// File: rtl/mul_cfg_sequencer.sv
// mul_cfg_sequencer: per-tile precision/approximation mask scheduler with drain between tiles
module mul_cfg_sequencer #(
    parameter int N_BIT_RES    = 12,
    parameter int N_BIT_APPR   = 8,
    parameter int N_CFG        = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cfg_we,
    input  logic [$clog2(N_CFG)-1:0]   i_cfg_addr,
    input  logic [4:0]                 i_cfg_res_bits,
    input  logic [3:0]                 i_cfg_appr_bits,
    input  logic [$clog2(N_CFG):0]     i_n_cfg,
    input  logic [15:0]                i_n_tiles,
    input  logic                       i_start,
    input  logic                       i_tile_done,
    output logic [N_BIT_RES-1:0]       o_res_mask,
    output logic [N_BIT_APPR-1:0]      o_appr_mask,
    output logic                       o_en_ff,
    output logic                       o_feed_ok,
    output logic [$clog2(N_CFG)-1:0]   o_cfg_idx,
    output logic                       o_busy,
    output logic                       o_done
);
    localparam int AW = $clog2(N_CFG);
    localparam int CW = AW + 1;
    typedef enum logic [2:0] {IDLE, APPLY, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [4:0]            res_tbl_q [N_CFG];
    logic [4:0]            res_tbl_d [N_CFG];
    logic [3:0]            appr_tbl_q [N_CFG];
    logic [3:0]            appr_tbl_d [N_CFG];
    logic [15:0]           n_tiles_q, n_tiles_d, tile_q, tile_d;
    logic [CW-1:0]         n_cfg_q, n_cfg_d;
    logic [AW-1:0]         idx_q, idx_d, cfg_idx_q, cfg_idx_d;
    logic [3:0]            drain_q, drain_d;
    logic                  final_q, final_d;
    logic [N_BIT_RES-1:0]  res_mask_q, res_mask_d;
    logic [N_BIT_APPR-1:0] appr_mask_q, appr_mask_d;

    // Next-state logic: table writes, job bookkeeping and mask encoding on APPLY
    always_comb begin
        state_d     = state_q;
        res_tbl_d   = res_tbl_q;
        appr_tbl_d  = appr_tbl_q;
        n_tiles_d   = n_tiles_q;
        tile_d      = tile_q;
        n_cfg_d     = n_cfg_q;
        idx_d       = idx_q;
        cfg_idx_d   = cfg_idx_q;
        drain_d     = drain_q;
        final_d     = final_q;
        res_mask_d  = res_mask_q;
        appr_mask_d = appr_mask_q;
        if (i_cfg_we) begin
            res_tbl_d[i_cfg_addr]  = i_cfg_res_bits;
            appr_tbl_d[i_cfg_addr] = i_cfg_appr_bits;
        end
        case (state_q)
            IDLE: if (i_start) begin
                if (i_n_tiles == '0) begin
                    state_d = DONE;
                end else begin
                    n_tiles_d = i_n_tiles;
                    n_cfg_d   = (i_n_cfg == '0) ? CW'(1) : (i_n_cfg > CW'(N_CFG)) ? CW'(N_CFG) : i_n_cfg;
                    tile_d    = '0;
                    idx_d     = '0;
                    final_d   = 1'b0;
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                // Bit compares against the raw field give the clamped encodings for free
                for (int k = 0; k < N_BIT_RES; k++) res_mask_d[k] = (k + 4) < int'(res_tbl_q[idx_q]);
                for (int k = 0; k < N_BIT_APPR; k++) appr_mask_d[k] = k >= int'(appr_tbl_q[idx_q]);
                cfg_idx_d = idx_q;
                state_d   = RUN;
            end
            RUN: if (i_tile_done) begin
                drain_d = 4'(DRAIN_CYCLES - 1);
                state_d = DRAIN;
                if (tile_q == n_tiles_q - 16'd1) begin
                    final_d = 1'b1;
                end else begin
                    tile_d = tile_q + 16'd1;
                    idx_d  = (CW'(idx_q) + CW'(1) == n_cfg_q) ? '0 : idx_q + AW'(1);
                end
            end
            DRAIN: begin
                state_d = (drain_q == '0) ? (final_q ? DONE : APPLY) : DRAIN;
                drain_d = (drain_q == '0) ? drain_q : drain_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset to exact/full-precision defaults
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            for (int i = 0; i < N_CFG; i++) begin
                res_tbl_q[i]  <= 5'd16;
                appr_tbl_q[i] <= 4'd0;
            end
            n_tiles_q   <= '0;
            tile_q      <= '0;
            n_cfg_q     <= CW'(1);
            idx_q       <= '0;
            cfg_idx_q   <= '0;
            drain_q     <= '0;
            final_q     <= 1'b0;
            res_mask_q  <= '1;
            appr_mask_q <= '1;
        end else begin
            state_q     <= state_d;
            res_tbl_q   <= res_tbl_d;
            appr_tbl_q  <= appr_tbl_d;
            n_tiles_q   <= n_tiles_d;
            tile_q      <= tile_d;
            n_cfg_q     <= n_cfg_d;
            idx_q       <= idx_d;
            cfg_idx_q   <= cfg_idx_d;
            drain_q     <= drain_d;
            final_q     <= final_d;
            res_mask_q  <= res_mask_d;
            appr_mask_q <= appr_mask_d;
        end
    end

    assign o_res_mask  = res_mask_q;
    assign o_appr_mask = appr_mask_q;
    assign o_cfg_idx   = cfg_idx_q;
    assign o_en_ff     = (state_q == RUN) || (state_q == DRAIN);
    assign o_feed_ok   = (state_q == RUN);
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
endmodule

// File: tb/tb_mul_cfg_sequencer.sv
// tb_mul_cfg_sequencer: scoreboard bench with a job-level reference model
module tb_mul_cfg_sequencer;
    localparam int D = 3;
    logic        clk = 0, rst = 1;
    logic        cfg_we = 0;
    logic [1:0]  cfg_addr = 0;
    logic [4:0]  cfg_res = 0;
    logic [3:0]  cfg_appr = 0;
    logic [2:0]  n_cfg = 0;
    logic [15:0] n_tiles = 0;
    logic        start = 0, tile_done = 0;
    logic [11:0] res_mask;
    logic [7:0]  appr_mask;
    logic        en_ff, feed_ok, busy, done;
    logic [1:0]  cfg_idx;

    mul_cfg_sequencer #(.N_BIT_RES(12), .N_BIT_APPR(8), .N_CFG(4), .DRAIN_CYCLES(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
        .i_cfg_res_bits(cfg_res), .i_cfg_appr_bits(cfg_appr), .i_n_cfg(n_cfg),
        .i_n_tiles(n_tiles), .i_start(start), .i_tile_done(tile_done),
        .o_res_mask(res_mask), .o_appr_mask(appr_mask), .o_en_ff(en_ff),
        .o_feed_ok(feed_ok), .o_cfg_idx(cfg_idx), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        int         idx;
        logic [11:0] rm;
        logic [7:0]  am;
    } exp_t;
    exp_t sb[$];

    int total = 0, bad = 0;
    int tbl_r[4], tbl_a[4];
    logic [11:0] last_rm = 12'hFFF;
    logic [7:0]  last_am = 8'hFF;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [11:0] m_res(input int rb);
        int r = (rb < 4) ? 4 : (rb > 16) ? 16 : rb;
        return 12'((1 << (r - 4)) - 1);
    endfunction

    function automatic logic [7:0] m_appr(input int ab);
        int a = (ab > 8) ? 8 : ab;
        return 8'(~((1 << a) - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin tbl_r[i] = 16; tbl_a[i] = 0; end
        last_rm = 12'hFFF;
        last_am = 8'hFF;
    endtask

    task automatic push_job(input int nt, input int nc);
        int c = (nc < 1) ? 1 : (nc > 4) ? 4 : nc;
        exp_t e;
        for (int t = 0; t < nt; t++) begin
            e.is_done = 0;
            e.idx = t % c;
            e.rm = m_res(tbl_r[e.idx]);
            e.am = m_appr(tbl_a[e.idx]);
            last_rm = e.rm;
            last_am = e.am;
            sb.push_back(e);
        end
        e.is_done = 1;
        e.idx = 0;
        e.rm = last_rm;
        e.am = last_am;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int r, input int ap);
        step();
        cfg_we = 1; cfg_addr = 2'(a); cfg_res = 5'(r); cfg_appr = 4'(ap);
        tbl_r[a] = r; tbl_a[a] = ap;
        step();
        cfg_we = 0;
    endtask

    task automatic wait_feed();
        int n = 0;
        while (!feed_ok && n < 50) begin step(); n++; end
        chk("feed_timeout", int'(feed_ok), 1);
    endtask

    task automatic run_job(input int nt, input int nc, input bit inject);
        int k;
        step();
        start = 1; n_tiles = 16'(nt); n_cfg = 3'(nc);
        push_job(nt, nc);
        step();
        start = 0;
        if (nt == 0) begin
            chk("done_cycle1", int'(done), 1);
            step();
            chk("idle_after_empty", int'(busy), 0);
            return;
        end
        chk("apply_cycle1", int'({busy, feed_ok, en_ff}), 3'b100);
        step();
        chk("run_cycle2", int'({feed_ok, en_ff}), 2'b11);
        for (int t = 0; t < nt; t++) begin
            wait_feed();
            repeat ($urandom_range(0, 4)) step();
            if (inject && $urandom_range(0, 1) == 1) begin
                start = 1; n_tiles = 16'd9; n_cfg = 3'd2;
                step();
                start = 0;
            end
            tile_done = 1;
            step();
            tile_done = 0;
            if (t == nt - 1) begin
                k = 1;
                while (!done && k < 40) begin step(); k++; end
                chk("done_latency", k, D + 1);
                step();
                chk("idle_after_done", int'(busy), 0);
                tile_done = 1;
                step();
                tile_done = 0;
                chk("tile_done_in_idle", int'(busy), 0);
            end else if (inject && $urandom_range(0, 1) == 1) begin
                tile_done = 1;
                step();
                tile_done = 0;
            end
        end
    endtask

    // Monitor: pops the scoreboard at each RUN entry and at o_done, checks drain shape
    bit prev_feed = 0, prev_en = 0, had_run = 0;
    logic [11:0] prev_rm;
    logic [7:0]  prev_am;
    int gap = 0, en_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_feed = 0; prev_en = 0; had_run = 0; gap = 0; en_cnt = 0;
        end else begin
            exp_t e;
            if (prev_en && en_ff) chk("mask_stable", int'({res_mask, appr_mask}), int'({prev_rm, prev_am}));
            if (feed_ok && !prev_feed) begin
                if (had_run) begin
                    chk("feed_gap", gap, D + 1);
                    chk("drain_en_cycles", en_cnt, D);
                end else chk("apply_gap", gap, 1);
                chk("apply_en_low", int'(prev_en), 0);
                chk("sb_has_tile", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("tile_kind", int'(e.is_done), 0);
                    chk("cfg_idx", int'(cfg_idx), e.idx);
                    chk("res_mask", int'(res_mask), int'(e.rm));
                    chk("appr_mask", int'(appr_mask), int'(e.am));
                end
                had_run = 1; gap = 0; en_cnt = 0;
            end
            if (done) begin
                chk("sb_has_done", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("done_kind", int'(e.is_done), 1);
                    chk("done_res_mask", int'(res_mask), int'(e.rm));
                    chk("done_appr_mask", int'(appr_mask), int'(e.am));
                end
                chk("done_en_low", int'(en_ff), 0);
            end
            if (busy && !feed_ok) begin
                gap++;
                if (en_ff) en_cnt++;
            end
            if (!busy) begin gap = 0; en_cnt = 0; had_run = 0; end
            prev_feed = feed_ok; prev_en = en_ff; prev_rm = res_mask; prev_am = appr_mask;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_res_mask", int'(res_mask), 12'hFFF);
        chk("rst_appr_mask", int'(appr_mask), 8'hFF);
        chk("rst_en_ff", int'(en_ff), 0);
        chk("rst_feed_ok", int'(feed_ok), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_idx", int'(cfg_idx), 0);
        run_job(1, 1, 0);
        wr(0, 8, 2);
        run_job(1, 1, 0);
        wr(0, 16, 0); wr(1, 12, 4); wr(2, 4, 8);
        run_job(5, 3, 1);
        wr(0, 2, 15);
        run_job(2, 0, 0);
        run_job(0, 2, 0);
        run_job(3, 7, 1);
        // Abort in DRAIN: no done pulse, table returns to exact defaults
        step();
        start = 1; n_tiles = 16'd3; n_cfg = 3'd1;
        push_job(3, 1);
        step();
        start = 0;
        wait_feed();
        tile_done = 1;
        step();
        tile_done = 0;
        step();
        rst = 1;
        sb.delete();
        model_reset();
        step();
        step();
        rst = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_res_mask", int'(res_mask), 12'hFFF);
        repeat (6) step();
        run_job(2, 2, 0);
        for (int j = 0; j < 20; j++) begin
            for (int a = 0; a < 4; a++)
                if ($urandom_range(0, 1) == 1) wr(a, $urandom_range(0, 20), $urandom_range(0, 15));
            run_job($urandom_range(0, 6), $urandom_range(0, 7), 1);
        end
        repeat (5) step();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
